accum_ctrl: RTL and testbench
=============================

ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): NREQ, 2, number of update requesters; DEPTH, 256, number of accumulator entries swept by a drain; RD_LAT, 2, array cycles from arr_addr to valid arr_q.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 The block SHALL have these requester ports: upd_valid  in  NREQ  per-requester update request; upd_ready  out  NREQ  per-requester grant/accept; upd_addr  in  NREQx32  entry index; upd_key  in  NREQx32  word key; upd_inc  in  NREQx32  count increment.
REQ-004 The block SHALL have these drain ports: drain_start  in  1  start pulse; drain_busy  out  1  sweep in progress; drain_done  out  1  one-cycle completion pulse.
REQ-005 The block SHALL have these result ports: out_valid  out  1  result present; out_ready  in  1  consumer accept; out_addr  out  32  entry index; out_data  out  64  {key[63:32], count[31:0]}.
REQ-006 The block SHALL have these array ports: arr_addr  out  32; arr_din  out  64  {key, inc}; arr_we  out  1; arr_q  in  64.

Function
REQ-007 An update SHALL transfer on a cycle where upd_valid[i] and upd_ready[i] are both 1.
REQ-008 At most one upd_ready bit SHALL be 1 per cycle, and it SHALL be 1 only when the matching upd_valid bit is 1, the FSM is IDLE, and drain_start is 0.
REQ-009 Grants SHALL be round-robin: the pointer starts at 0 and moves past the last granted index; with all requesters valid, grants SHALL rotate 0,1,...,NREQ-1,0.
REQ-010 In the cycle after a transfer, arr_we SHALL be 1 for exactly one cycle, with arr_addr=upd_addr and arr_din={upd_key, upd_inc} as registered from the transfer.
REQ-011 The FSM SHALL have the states IDLE, ISSUE, WAIT, EMIT and DONE.
REQ-012 IDLE->ISSUE SHALL occur on drain_start=1; drain_start SHALL win over any upd_valid in the same cycle, and an update write already registered SHALL still complete.
REQ-013 In ISSUE the block SHALL drive arr_addr=idx with arr_we=0, then enter WAIT.
REQ-014 WAIT SHALL last RD_LAT cycles, after which the block SHALL capture arr_q into out_data, set out_addr=idx, and enter EMIT.
REQ-015 In EMIT, out_valid SHALL be 1. On out_ready: if idx=DEPTH-1 the FSM SHALL go to DONE, otherwise idx SHALL increment and the FSM SHALL go to ISSUE.
REQ-016 Under out_ready=0, out_valid, out_addr and out_data SHALL hold stable.
REQ-017 DONE SHALL last one cycle with drain_done=1, then return to IDLE with idx=0.
REQ-018 drain_busy SHALL be 1 in ISSUE, WAIT and EMIT, and 0 otherwise.
REQ-019 drain_start SHALL be ignored while drain_busy=1.
REQ-020 arr_we SHALL never be 1 in ISSUE, WAIT, EMIT or DONE; a drain SHALL never overlap an update write.
REQ-021 idx SHALL be 32 bits, counting 0..DEPTH-1, with no wrap beyond DEPTH-1.
REQ-022 Throughput: one update per cycle in IDLE; a drain SHALL take DEPTH*(RD_LAT+2)+1 cycles under continuous out_ready.

Reset
REQ-023 On reset=1 at a clock edge: FSM=IDLE, idx=0, RR pointer=0, upd_ready=0, arr_we=0, arr_addr=0, arr_din=0, out_valid=0, out_addr=0, out_data=0, drain_busy=0, drain_done=0.
REQ-024 Reset mid-drain SHALL abort the sweep with no drain_done pulse; reset SHALL cancel a registered but unissued update write.

Structure
REQ-025 A shared package accum_pkg SHALL hold the FSM state enum, the 32-bit key/count/addr widths, and the 64-bit entry layout (KEY_MSB=63, KEY_LSB=32, CNT_MSB=31).
REQ-026 The round-robin arbiter SHALL be a sub-module, rr_arbiter (parameter NREQ; inputs req, enable; outputs one-hot grant).

Verification
REQ-027 Single update: requester 0 sends addr=0, key=DEADBEEF, inc=1 -> the next cycle arr_we=1, arr_addr=0, arr_din=DEADBEEF_00000001.
REQ-028 Contention: both requesters valid for 4 cycles -> grants 0,1,0,1 and exactly 4 arr_we pulses.
REQ-029 Drain with DEPTH=4 after updates of 5x addr0 and 3x addr1 -> out_data sequence {DEADBEEF,5}, {ABADCAFE,3}, {FEFEFEFE,1}, {34343434,1}, then drain_done pulses once.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in EMIT -> out_valid stays 1 with out_data stable, and no further arr_addr changes.
REQ-031 Simultaneous drain_start and upd_valid -> upd_ready=0 and drain_busy=1 the next cycle; the update is taken only after drain_done.
REQ-032 Reset asserted in WAIT -> next cycle all outputs at reset values, with no drain_done pulse.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and field layout for the accumulator drain controller.
// Holds the FSM state encoding, the 32-bit key/count/addr widths and the
// 64-bit entry layout {key[63:32], count[31:0]} used on arr_din/arr_q/out_data.
package accum_pkg;

  localparam int ADDR_W  = 32;
  localparam int KEY_W   = 32;
  localparam int CNT_W   = 32;
  localparam int ENTRY_W = KEY_W + CNT_W;

  localparam int KEY_MSB = 63;
  localparam int KEY_LSB = 32;
  localparam int CNT_MSB = 31;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational from req/enable; pointer advances on the clock edge.
// Backpressure: enable=0 forces grant to zero and freezes the pointer.
// Ports: clk, reset (sync, active high); req[NREQ] requests; enable gates granting;
//        grant[NREQ] one-hot grant (only ever set on a requesting bit).
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (enable && found) begin
      grant[win] = 1'b1;
    end
  end

  // Pointer moves just past the granted index so that index goes to the back.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// Accumulator front end: arbitrates update writes into an external array and sweeps it on drain.
// Latency: update write one cycle after transfer; each drained entry takes RD_LAT+2 cycles, +1 for DONE.
// Backpressure: upd_ready drops during a drain; out_ready=0 holds the result stable in EMIT.
// Ports: clk/reset; upd_valid/ready/addr/key/inc per requester; drain_start/busy/done;
//        out_valid/ready/addr/data result stream; arr_addr/din/we/q external array (arr_q valid RD_LAT after arr_addr).
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            upd_valid,
  output logic [NREQ-1:0]            upd_ready,
  input  logic [NREQ-1:0][ADDR_W-1:0] upd_addr,
  input  logic [NREQ-1:0][KEY_W-1:0]  upd_key,
  input  logic [NREQ-1:0][CNT_W-1:0]  upd_inc,
  input  logic                       drain_start,
  output logic                       drain_busy,
  output logic                       drain_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [ENTRY_W-1:0]         out_data,
  output logic [ADDR_W-1:0]          arr_addr,
  output logic [ENTRY_W-1:0]         arr_din,
  output logic                       arr_we,
  input  logic [ENTRY_W-1:0]         arr_q
);

  localparam int                WCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [WCW-1:0]      wait_cnt;
  logic                wait_done;
  logic                last_idx;
  logic                arb_en;
  logic [NREQ-1:0]     grant;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [KEY_W-1:0]    sel_key;
  logic [CNT_W-1:0]    sel_inc;
  logic                wr_we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0]  wr_din;

  // Updates are only granted in IDLE, and drain_start takes priority. A write
  // registered in the cycle drain_start arrives still lands in that IDLE cycle,
  // so the array port is never shared between a write and a drain read.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (upd_valid),
    .enable (arb_en),
    .grant  (grant)
  );

  assign upd_ready = grant;
  assign xfer      = |(upd_valid & grant);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign last_idx  = (idx == LAST_IDX);

  always_comb begin
    sel_addr = '0;
    sel_key  = '0;
    sel_inc  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = upd_addr[i];
        sel_key  = upd_key[i];
        sel_inc  = upd_inc[i];
      end
    end
  end

  // The array address follows the pending write in IDLE and the sweep index
  // otherwise, so it stays parked on idx while a result waits in EMIT.
  assign arr_addr = (state == IDLE) ? wr_addr : idx;
  assign arr_din  = wr_din;
  assign arr_we   = wr_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    out_valid  = 1'b0;
    drain_busy = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        arb_en = !drain_start;
        if (drain_start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        drain_busy = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        drain_busy = 1'b1;
        if (wait_done) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        drain_busy = 1'b1;
        out_valid  = 1'b1;
        if (out_ready) begin
          state_nxt = last_idx ? DONE : ISSUE;
        end
      end
      DONE: begin
        drain_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      wait_cnt <= '0;
      wr_we    <= 1'b0;
      wr_addr  <= '0;
      wr_din   <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      wr_we <= xfer;
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_din  <= {sel_key, sel_inc};
      end
      case (state)
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (wait_done) begin
            wait_cnt <= '0;
            out_addr <= idx;
            out_data <= {arr_q[KEY_MSB:KEY_LSB], arr_q[CNT_MSB:0]};
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready && !last_idx) begin
            idx <= idx + 1'b1;
          end
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
module tb_accum_ctrl;

  localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
  localparam logic [63:0] A1 = 64'hABADCAFE_00000001;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       upd_valid;
  logic [1:0]       upd_ready;
  logic [1:0][31:0] upd_addr;
  logic [1:0][31:0] upd_key;
  logic [1:0][31:0] upd_inc;
  logic             drain_start;
  logic             drain_busy;
  logic             drain_done;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [63:0]      out_data;
  logic [31:0]      arr_addr;
  logic [63:0]      arr_din;
  logic             arr_we;
  logic [63:0]      arr_q;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  accum_ctrl #(
    .NREQ   (2),
    .DEPTH  (4),
    .RD_LAT (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_addr    (upd_addr),
    .upd_key     (upd_key),
    .upd_inc     (upd_inc),
    .drain_start (drain_start),
    .drain_busy  (drain_busy),
    .drain_done  (drain_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .arr_addr    (arr_addr),
    .arr_din     (arr_din),
    .arr_we      (arr_we),
    .arr_q       (arr_q)
  );

  // Accumulating array: a write adds the increment to the stored count and
  // replaces the key; reads arrive two cycles after the address.
  logic [63:0] mem [4];
  logic [63:0] rd1;

  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 64'h0;
      mem[1] <= 64'h0;
      mem[2] <= 64'hFEFEFEFE_00000001;
      mem[3] <= 64'h34343434_00000001;
    end else if (arr_we) begin
      mem[arr_addr[1:0]] <= {arr_din[63:32], mem[arr_addr[1:0]][31:0] + arr_din[31:0]};
    end
    rd1   <= mem[arr_addr[1:0]];
    arr_q <= rd1;
  end

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic        we;
    logic [31:0] addr;
    logic [63:0] din;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] exp_data [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are checked 1ns later.
  task automatic apply(input logic [1:0] vld, input logic ds, input logic ordy);
    @(negedge clk);
    upd_valid   = vld;
    drain_start = ds;
    out_ready   = ordy;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " upd_ready"},  64'(upd_ready),  64'h0);
    chk({tag, " arr_we"},     64'(arr_we),     64'h0);
    chk({tag, " arr_addr"},   64'(arr_addr),   64'h0);
    chk({tag, " arr_din"},    arr_din,         64'h0);
    chk({tag, " out_valid"},  64'(out_valid),  64'h0);
    chk({tag, " out_addr"},   64'(out_addr),   64'h0);
    chk({tag, " out_data"},   out_data,        64'h0);
    chk({tag, " drain_busy"}, 64'(drain_busy), 64'h0);
    chk({tag, " drain_done"}, 64'(drain_done), 64'h0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 2'b01, 1'b0, 32'd0, 64'h0};
    tbl[1] = '{2'b10, 2'b10, 1'b1, 32'd0, D1};
    tbl[2] = '{2'b11, 2'b01, 1'b1, 32'd1, A1};
    tbl[3] = '{2'b11, 2'b10, 1'b1, 32'd0, D1};
    tbl[4] = '{2'b11, 2'b01, 1'b1, 32'd1, A1};
    tbl[5] = '{2'b11, 2'b10, 1'b1, 32'd0, D1};
    tbl[6] = '{2'b00, 2'b00, 1'b1, 32'd1, A1};
    tbl[7] = '{2'b01, 2'b01, 1'b0, 32'd1, A1};
    tbl[8] = '{2'b00, 2'b00, 1'b1, 32'd0, D1};
    tbl[9] = '{2'b00, 2'b00, 1'b0, 32'd0, D1};
    exp_data[0] = 64'hDEADBEEF_00000005;
    exp_data[1] = 64'hABADCAFE_00000003;
    exp_data[2] = 64'hFEFEFEFE_00000001;
    exp_data[3] = 64'h34343434_00000001;

    reset       = 1'b1;
    upd_valid   = 2'b00;
    drain_start = 1'b0;
    out_ready   = 1'b1;
    upd_addr[0] = 32'd0;
    upd_key[0]  = 32'hDEADBEEF;
    upd_inc[0]  = 32'd1;
    upd_addr[1] = 32'd1;
    upd_key[1]  = 32'hABADCAFE;
    upd_inc[1]  = 32'd1;

    apply(2'b00, 1'b0, 1'b1);
    apply(2'b00, 1'b0, 1'b1);
    chk_reset_vals("init");
    reset = 1'b0;

    // Update phase: single update, rotating contention, pointer behaviour.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].vld, 1'b0, 1'b1);
      chk($sformatf("v%0d upd_ready", i), 64'(upd_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d arr_we", i),    64'(arr_we),    64'(tbl[i].we));
      chk($sformatf("v%0d arr_addr", i),  64'(arr_addr),  64'(tbl[i].addr));
      chk($sformatf("v%0d arr_din", i),   arr_din,        tbl[i].din);
      chk($sformatf("v%0d drain_busy", i), 64'(drain_busy), 64'h0);
    end

    // Pointer sits at 1 with only requester 0 asking: still granted.
    apply(2'b01, 1'b0, 1'b1);
    chk("wrap upd_ready", 64'(upd_ready), 64'h1);
    // drain_start with a live request: no grant, pending write still lands.
    apply(2'b01, 1'b1, 1'b1);
    chk("ds upd_ready", 64'(upd_ready), 64'h0);
    chk("ds arr_we",    64'(arr_we),    64'h1);
    chk("ds arr_din",   arr_din,        D1);
    chk("ds busy",      64'(drain_busy), 64'h0);

    // Drain sweep with a 10-cycle stall on entry 0 and an ignored drain_start.
    for (int e = 0; e < 4; e++) begin
      apply(2'b01, 1'b0, 1'b1);
      chk($sformatf("e%0d issue busy", e),   64'(drain_busy), 64'h1);
      chk($sformatf("e%0d issue addr", e),   64'(arr_addr),   64'(e));
      chk($sformatf("e%0d issue we", e),     64'(arr_we),     64'h0);
      chk($sformatf("e%0d issue ready", e),  64'(upd_ready),  64'h0);
      chk($sformatf("e%0d issue valid", e),  64'(out_valid),  64'h0);
      for (int w = 0; w < 2; w++) begin
        apply(2'b01, (e == 1 && w == 0), 1'b1);
        chk($sformatf("e%0d wait%0d valid", e, w), 64'(out_valid), 64'h0);
        chk($sformatf("e%0d wait%0d busy", e, w),  64'(drain_busy), 64'h1);
        chk($sformatf("e%0d wait%0d addr", e, w),  64'(arr_addr),   64'(e));
        chk($sformatf("e%0d wait%0d done", e, w),  64'(drain_done), 64'h0);
      end
      if (e == 0) begin
        for (int s = 0; s < 10; s++) begin
          apply(2'b01, 1'b0, 1'b0);
          chk($sformatf("stall%0d valid", s), 64'(out_valid), 64'h1);
          chk($sformatf("stall%0d data", s),  out_data,       exp_data[0]);
          chk($sformatf("stall%0d addr", s),  64'(arr_addr),  64'h0);
        end
      end
      apply(2'b01, 1'b0, 1'b1);
      chk($sformatf("e%0d emit valid", e), 64'(out_valid), 64'h1);
      chk($sformatf("e%0d emit addr", e),  64'(out_addr),  64'(e));
      chk($sformatf("e%0d emit data", e),  out_data,       exp_data[e]);
      chk($sformatf("e%0d emit ready", e), 64'(upd_ready), 64'h0);
    end

    apply(2'b01, 1'b0, 1'b1);
    chk("done pulse", 64'(drain_done), 64'h1);
    chk("done busy",  64'(drain_busy), 64'h0);
    chk("done ready", 64'(upd_ready),  64'h0);
    apply(2'b01, 1'b0, 1'b1);
    chk("post done pulse", 64'(drain_done), 64'h0);
    chk("post ready",      64'(upd_ready),  64'h1);
    apply(2'b00, 1'b0, 1'b1);
    chk("post we",   64'(arr_we),   64'h1);
    chk("post addr", 64'(arr_addr), 64'h0);

    // Second drain restarts at entry 0; reset in WAIT aborts it.
    apply(2'b00, 1'b1, 1'b1);
    chk("d2 start busy", 64'(drain_busy), 64'h0);
    apply(2'b00, 1'b0, 1'b1);
    chk("d2 issue busy", 64'(drain_busy), 64'h1);
    chk("d2 issue addr", 64'(arr_addr),   64'h0);
    apply(2'b00, 1'b0, 1'b1);
    chk("d2 wait busy", 64'(drain_busy), 64'h1);
    reset = 1'b1;
    apply(2'b00, 1'b0, 1'b1);
    chk_reset_vals("rst");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      apply(2'b00, 1'b0, 1'b1);
      chk($sformatf("rst%0d done", c), 64'(drain_done), 64'h0);
      chk($sformatf("rst%0d busy", c), 64'(drain_busy), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
